// File: rtl/serial_add_arbiter_pkg.sv
// rtl/serial_add_arbiter_pkg.sv - shared types and defaults for the serial adder arbiter
package serial_add_arbiter_pkg;

    // Transaction phases: wait for a winner, wait for the adder, report
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int RR_PTR_W    = $clog2(DEF_NUM_REQ);
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/serial_add_arbiter_rr_picker.sv
// rtl/serial_add_arbiter_rr_picker.sv - round-robin winner selection starting at ptr
module serial_add_arbiter_rr_picker
    import serial_add_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = RR_PTR_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Scan upward from ptr with wrap-around; first asserted request wins
    always_comb begin
        int            s;
        logic [ID_W-1:0] pos;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            s = int'(ptr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            pos = s[ID_W-1:0];
            if (!any && req[pos]) begin
                any         = 1'b1;
                onehot[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/serial_add_arbiter.sv
// rtl/serial_add_arbiter.sv - shares one serial adder between requesters, round-robin
module serial_add_arbiter
    import serial_add_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = 32,
    parameter int ID_W    = RR_PTR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     rsp_err,
    output logic                     add_start,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_carry,
    input  logic                     add_done,
    output logic                     busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state, state_d;
    logic [ID_W-1:0]    ptr, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] gnt_d;
    logic               start_d, rv_d, rc_d, re_d, busy_d;
    logic [WIDTH-1:0]   a_d, b_d, rsum_d;
    logic [ID_W-1:0]    rid_d;

    logic [NUM_REQ-1:0] win_onehot;
    logic [ID_W-1:0]    win_idx;
    logic               win_any;
    logic               launch;
    logic               timeout_hit;

    logic [WIDTH-1:0]   a_arr [NUM_REQ];
    logic [WIDTH-1:0]   b_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    serial_add_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    // A done level left over from the last operation must fall before a new launch
    assign launch      = (state == ST_IDLE) && win_any && !add_done;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // Next-state: launch, wait for done or timeout, report for one cycle
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (launch) state_d = ST_WAIT;
            ST_WAIT: if (add_done || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of every registered output and of the transaction bookkeeping
    always_comb begin
        ptr_d   = ptr;
        id_d    = id_q;
        cnt_d   = cnt;
        sum_d   = sum_q;
        carry_d = carry_q;
        err_d   = err_q;
        gnt_d   = '0;
        start_d = 1'b0;
        a_d     = add_a;
        b_d     = add_b;
        rv_d    = 1'b0;
        rid_d   = rsp_id;
        rsum_d  = rsp_sum;
        rc_d    = rsp_carry;
        re_d    = rsp_err;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    gnt_d   = win_onehot;
                    start_d = 1'b1;
                    a_d     = a_arr[win_idx];
                    b_d     = b_arr[win_idx];
                    id_d    = win_idx;
                    cnt_d   = '0;
                    ptr_d   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt + 1'b1;
                if (add_done) begin
                    sum_d   = add_sum;
                    carry_d = add_carry;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    sum_d   = '0;
                    carry_d = 1'b0;
                    err_d   = 1'b1;
                end
            end
            ST_RESP: begin
                rv_d   = 1'b1;
                rid_d  = id_q;
                rsum_d = sum_q;
                rc_d   = carry_q;
                re_d   = err_q;
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            id_q      <= '0;
            cnt       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            gnt       <= '0;
            add_start <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            id_q      <= id_d;
            cnt       <= cnt_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            err_q     <= err_d;
            gnt       <= gnt_d;
            add_start <= start_d;
            add_a     <= a_d;
            add_b     <= b_d;
            rsp_valid <= rv_d;
            rsp_id    <= rid_d;
            rsp_sum   <= rsum_d;
            rsp_carry <= rc_d;
            rsp_err   <= re_d;
            busy      <= busy_d;
        end
    end

endmodule
